// File: rtl/ascii_text_injector.sv
// ascii_text_injector: buffers OSD "Load Ascii" bytes from the ioctl port, normalises
//    line endings and feeds them one at a time to the ACIA receive path, paced for the 6502.
// Latency: strobe accepted in cycle N -> out_valid in cycle N+2 (FIFO empty, FSM idle).
// Backpressure: registered ioctl_wait at count >= DEPTH-1 (one slot of slack); strobes
//    landing on a full FIFO are dropped and latch overflow; out_data holds until out_ready.
//
// Ports:
//    clk_sys, reset           - only clock; synchronous active-high reset
//    enable                   - 1 = file source selected; 0 flushes and idles the block
//    ioctl_download/wr/data   - hps_io download port (wr is a one-cycle byte strobe)
//    ioctl_wait               - back-pressure to hps_io
//    out_data/valid/ready     - byte handshake toward the ACIA receive path
//    busy                     - injection in progress (LED_USER, UART source mux)
//    overflow                 - sticky: a byte was dropped since the last download start
//
// Build option: define ASCII_TEXT_INJECTOR_UPCASE_EN to fold a-z to A-Z at push time.

module ascii_text_injector #(
   parameter int DEPTH    = 16,       // power of two, >= 4
   parameter int CHAR_GAP = 48000,    // cycles between bytes
   parameter int LINE_GAP = 960000,   // cycles after an emitted CR
   parameter int CNT_W    = 20        // must hold max(CHAR_GAP, LINE_GAP)
) (
   input  logic       clk_sys,
   input  logic       reset,
   input  logic       enable,
   input  logic       ioctl_download,
   input  logic       ioctl_wr,
   input  logic [7:0] ioctl_data,
   output logic       ioctl_wait,
   output logic [7:0] out_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       busy,
   output logic       overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   localparam logic [CW-1:0]    FULL_CNT  = CW'(DEPTH);
   localparam logic [CW-1:0]    WAIT_CNT  = CW'(DEPTH - 1);
   localparam logic [CNT_W-1:0] CHAR_LOAD = CNT_W'(CHAR_GAP - 1);
   localparam logic [CNT_W-1:0] LINE_LOAD = CNT_W'(LINE_GAP - 1);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_PRESENT = 2'd1;
   localparam logic [1:0] S_GAP     = 2'd2;

   logic [7:0]       mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic [CW-1:0]    count_nxt;
   logic [1:0]       state;
   logic [CNT_W-1:0] gap_cnt;
   logic             dl_prev;
   logic             prev_cr;

   logic             dl_rise;
   logic             flush;
   logic             is_cr;
   logic             is_lf;
   logic             is_nul;
   logic             keep;
   logic             push;
   logic             pop;
   logic             drop;
   logic [7:0]       filt_dat;
   logic [7:0]       push_dat;

   // Push-side filter: drop NUL, drop LF directly after CR, store a lone LF as CR.
   always_comb begin
      is_cr    = (ioctl_data == 8'h0D);
      is_lf    = (ioctl_data == 8'h0A);
      is_nul   = (ioctl_data == 8'h00);
      keep     = ioctl_wr && !is_nul && !(is_lf && prev_cr);
      filt_dat = is_lf ? 8'h0D : ioctl_data;
`ifdef ASCII_TEXT_INJECTOR_UPCASE_EN
      // UK101 BASIC only tokenises upper case.
      push_dat = ((filt_dat >= 8'h61) && (filt_dat <= 8'h7A)) ? (filt_dat & 8'hDF) : filt_dat;
`else
      push_dat = filt_dat;
`endif
   end

   // A new download or a deselected source discards everything queued.
   always_comb begin
      dl_rise = ioctl_download && !dl_prev;
      flush   = !enable || dl_rise;
      pop     = !flush && (state == S_IDLE) && (count != '0);
      // A full FIFO can still take a byte in the cycle it is popped.
      push    = !flush && keep && ((count != FULL_CNT) || pop);
      drop    = !flush && keep && (count == FULL_CNT) && !pop;
   end

   always_comb begin
      count_nxt = count;
      if (flush) begin
         count_nxt = '0;
      end else if (push && !pop) begin
         count_nxt = count + CW'(1);
      end else if (pop && !push) begin
         count_nxt = count - CW'(1);
      end
   end

   always_ff @(posedge clk_sys) begin
      if (push) begin
         mem[wr_ptr] <= push_dat;
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         ioctl_wait <= 1'b0;
         overflow   <= 1'b0;
         prev_cr    <= 1'b0;
         dl_prev    <= 1'b0;
      end else begin
         dl_prev    <= ioctl_download;
         count      <= count_nxt;
         // Raised one entry early so a strobe already in flight still fits.
         ioctl_wait <= (count_nxt >= WAIT_CNT);
         if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            prev_cr <= 1'b0;
            if (dl_rise) begin
               overflow <= 1'b0;
            end
         end else begin
            if (push) begin
               wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
               rd_ptr <= rd_ptr + AW'(1);
            end
            if (drop) begin
               overflow <= 1'b1;
            end
            // Any non-NUL byte that is not dropped updates CR tracking, including a
            // discarded LF, so CR LF LF yields two line ends rather than one.
            if (ioctl_wr && !is_nul && !drop) begin
               prev_cr <= is_cr;
            end
         end
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state    <= S_IDLE;
         out_data <= 8'h00;
         gap_cnt  <= '0;
      end else if (flush) begin
         state    <= S_IDLE;
         gap_cnt  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (pop) begin
                  out_data <= mem[rd_ptr];
                  state    <= S_PRESENT;
               end
            end
            S_PRESENT: begin
               if (out_ready) begin
                  // BASIC needs extra time to tokenise a finished line.
                  gap_cnt <= (out_data == 8'h0D) ? LINE_LOAD : CHAR_LOAD;
                  state   <= S_GAP;
               end
            end
            S_GAP: begin
               if (gap_cnt == '0) begin
                  state <= S_IDLE;
               end else begin
                  gap_cnt <= gap_cnt - CNT_W'(1);
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign out_valid = (state == S_PRESENT);
   assign busy      = enable && (ioctl_download || (count != '0) || (state != S_IDLE));

endmodule

// File: tb/tb_ascii_text_injector.sv
// tb_ascii_text_injector: directed scenarios for ascii_text_injector with short gaps.
// Latency: n/a (bench).
// Backpressure: out_ready driven per scenario; every wait on the DUT is cycle-bounded.

module tb_ascii_text_injector;

   localparam int DEPTH    = 16;
   localparam int CHAR_GAP = 6;
   localparam int LINE_GAP = 15;
   localparam int CNT_W    = 8;

   logic       clk_sys = 1'b0;
   logic       reset = 1'b1;
   logic       enable = 1'b0;
   logic       ioctl_download = 1'b0;
   logic       ioctl_wr = 1'b0;
   logic [7:0] ioctl_data = 8'h00;
   logic       ioctl_wait;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic       busy;
   logic       overflow;

   int         n_cmp = 0;
   int         n_err = 0;
   int         cyc = 0;
   logic [7:0] acc_q[$];
   int         acc_t[$];

   always #5 clk_sys = ~clk_sys;

   ascii_text_injector #(
      .DEPTH(DEPTH), .CHAR_GAP(CHAR_GAP), .LINE_GAP(LINE_GAP), .CNT_W(CNT_W)
   ) dut (
      .clk_sys(clk_sys), .reset(reset), .enable(enable),
      .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr), .ioctl_data(ioctl_data),
      .ioctl_wait(ioctl_wait), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .busy(busy), .overflow(overflow)
   );

   // Record every accepted byte with the cycle it was accepted in.
   always @(posedge clk_sys) begin
      if (out_valid && out_ready && !reset) begin
         acc_q.push_back(out_data);
         acc_t.push_back(cyc);
      end
      cyc <= cyc + 1;
   end

   task automatic tick;
      @(posedge clk_sys);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      ioctl_wr   = 1'b1;
      ioctl_data = b;
      tick();
      ioctl_wr   = 1'b0;
   endtask

   task automatic restart;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      acc_q.delete();
      acc_t.delete();
   endtask

   task automatic test_reset;
      reset = 1'b1;
      tick();
      tick();
      n_cmp++; if (ioctl_wait !== 1'b0) begin n_err++; $display("FAIL reset_wait: got %b want 0", ioctl_wait); end
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", out_valid); end
      n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h want 00", out_data); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", overflow); end
      reset = 1'b0;
   endtask

   task automatic test_basic;
      logic [7:0] exp_q[$];
      logic [7:0] got;
      int         dt;
      exp_q = '{8'h41, 8'h42, 8'h0D};
      restart();
      enable = 1'b1; out_ready = 1'b1; ioctl_download = 1'b1;
      tick();
      ioctl_wr = 1'b1; ioctl_data = 8'h41;
      tick();
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_lat_n1: got %b want 0", out_valid); end
      ioctl_data = 8'h42;
      tick();
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL basic_lat_n2: got %b want 1", out_valid); end
      n_cmp++; if (out_data !== 8'h41) begin n_err++; $display("FAIL basic_first: got %h want 41", out_data); end
      ioctl_data = 8'h0D;
      tick();
      ioctl_wr = 1'b0; ioctl_download = 1'b0;
      for (int i = 0; i < 500 && acc_q.size() < 3; i++) tick();
      n_cmp++; if (acc_q.size() !== 3) begin n_err++; $display("FAIL basic_count: got %0d want 3", acc_q.size()); end
      for (int i = 0; i < 3; i++) begin
         got = (i < acc_q.size()) ? acc_q[i] : 8'hxx;
         n_cmp++; if (got !== exp_q[i]) begin n_err++; $display("FAIL basic_byte%0d: got %h want %h", i, got, exp_q[i]); end
      end
      dt = (acc_t.size() >= 2) ? acc_t[1] - acc_t[0] : -1;
      n_cmp++; if (dt !== CHAR_GAP + 2) begin n_err++; $display("FAIL basic_char_gap: got %0d want %0d", dt, CHAR_GAP + 2); end
      for (int i = 0; i < 500 && busy; i++) tick();
      dt = (acc_t.size() >= 3) ? cyc - acc_t[2] : -1;
      n_cmp++; if (dt !== LINE_GAP + 1) begin n_err++; $display("FAIL basic_busy_fall: got %0d want %0d", dt, LINE_GAP + 1); end
   endtask

   task automatic test_line_endings;
      logic [7:0] in_q[$];
      logic [7:0] exp_q[$];
      logic [7:0] got;
      in_q  = '{8'h31, 8'h0D, 8'h0A, 8'h32, 8'h0A, 8'h0A};
      exp_q = '{8'h31, 8'h0D, 8'h32, 8'h0D, 8'h0D};
      restart();
      enable = 1'b1; out_ready = 1'b1; ioctl_download = 1'b1;
      tick();
      foreach (in_q[i]) send(in_q[i]);
      ioctl_download = 1'b0;
      for (int i = 0; i < 2000 && (busy || acc_q.size() < 5); i++) tick();
      n_cmp++; if (acc_q.size() !== 5) begin n_err++; $display("FAIL eol_count: got %0d want 5", acc_q.size()); end
      for (int i = 0; i < 5; i++) begin
         got = (i < acc_q.size()) ? acc_q[i] : 8'hxx;
         n_cmp++; if (got !== exp_q[i]) begin n_err++; $display("FAIL eol_byte%0d: got %h want %h", i, got, exp_q[i]); end
      end
   endtask

   // Leaves the download active and overflow set for test_restart.
   task automatic test_back_to_back;
      logic [7:0] got;
      logic       exp_wait;
      restart();
      enable = 1'b1; out_ready = 1'b0; ioctl_download = 1'b1;
      tick();
      // Strobe i leaves i bytes queued (strobe 0 moves on to out_data the next cycle).
      for (int i = 0; i < 17; i++) begin
         send(8'(8'h41 + i));
         exp_wait = (i >= DEPTH - 1);
         n_cmp++; if (ioctl_wait !== exp_wait) begin n_err++; $display("FAIL bp_wait%0d: got %b want %b", i, ioctl_wait, exp_wait); end
      end
      n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL bp_ovf_before: got %b want 0", overflow); end
      send(8'h52);
      n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL bp_ovf_after: got %b want 1", overflow); end
      out_ready = 1'b1;
      for (int i = 0; i < 2000 && acc_q.size() < 17; i++) tick();
      // The presented byte plus the 16 queued ones; the dropped 0x52 never appears.
      n_cmp++; if (acc_q.size() !== 17) begin n_err++; $display("FAIL bp_count: got %0d want 17", acc_q.size()); end
      for (int i = 0; i < 17; i++) begin
         got = (i < acc_q.size()) ? acc_q[i] : 8'hxx;
         n_cmp++; if (got !== 8'(8'h41 + i)) begin n_err++; $display("FAIL bp_byte%0d: got %h want %h", i, got, 8'(8'h41 + i)); end
      end
   endtask

   task automatic test_restart;
      acc_q.delete(); acc_t.delete();
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) send(8'(8'h31 + i));
      n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL rs_ovf_sticky: got %b want 1", overflow); end
      ioctl_download = 1'b0;
      tick();
      ioctl_download = 1'b1;
      tick();
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rs_valid: got %b want 0", out_valid); end
      n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL rs_ovf_clear: got %b want 0", overflow); end
      out_ready = 1'b1;
      send(8'h5A);
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rs_lat_n1: got %b want 0", out_valid); end
      tick();
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL rs_lat_n2: got %b want 1", out_valid); end
      n_cmp++; if (out_data !== 8'h5A) begin n_err++; $display("FAIL rs_data: got %h want 5a", out_data); end
      ioctl_download = 1'b0;
      for (int i = 0; i < 500 && busy; i++) tick();
      n_cmp++; if (acc_q.size() !== 1) begin n_err++; $display("FAIL rs_count: got %0d want 1", acc_q.size()); end
   endtask

   task automatic test_disable;
      restart();
      enable = 1'b1; out_ready = 1'b0; ioctl_download = 1'b1;
      tick();
      send(8'h41);
      tick();
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL dis_present: got %b want 1", out_valid); end
      enable = 1'b0;
      tick();
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL dis_valid: got %b want 0", out_valid); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL dis_busy: got %b want 0", busy); end
      send(8'h42);
      n_cmp++; if (ioctl_wait !== 1'b0) begin n_err++; $display("FAIL dis_wait: got %b want 0", ioctl_wait); end
      enable = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      n_cmp++; if (acc_q.size() !== 0) begin n_err++; $display("FAIL dis_ignored: got %0d want 0", acc_q.size()); end
      ioctl_download = 1'b0;
   endtask

   task automatic test_reset_in_gap;
      restart();
      enable = 1'b1; out_ready = 1'b1; ioctl_download = 1'b1;
      tick();
      send(8'h0D);
      ioctl_download = 1'b0;
      for (int i = 0; i < 100 && acc_q.size() < 1; i++) tick();
      tick(); tick(); tick();
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL rg_in_gap: got %b want 1", busy); end
      reset = 1'b1;
      tick();
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rg_valid: got %b want 0", out_valid); end
      n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("FAIL rg_data: got %h want 00", out_data); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rg_busy: got %b want 0", busy); end
      n_cmp++; if (ioctl_wait !== 1'b0) begin n_err++; $display("FAIL rg_wait: got %b want 0", ioctl_wait); end
      reset = 1'b0;
      for (int i = 0; i < LINE_GAP + 5; i++) tick();
      n_cmp++; if (acc_q.size() !== 1) begin n_err++; $display("FAIL rg_no_extra: got %0d want 1", acc_q.size()); end
   endtask

   task automatic test_upcase;
      logic [7:0] in_q[$];
      logic [7:0] exp_q[$];
      logic [7:0] got;
      in_q = '{8'h70, 8'h72, 8'h69, 8'h6E, 8'h74};
`ifdef ASCII_TEXT_INJECTOR_UPCASE_EN
      exp_q = '{8'h50, 8'h52, 8'h49, 8'h4E, 8'h54};
`else
      exp_q = '{8'h70, 8'h72, 8'h69, 8'h6E, 8'h74};
`endif
      restart();
      enable = 1'b1; out_ready = 1'b1; ioctl_download = 1'b1;
      tick();
      foreach (in_q[i]) send(in_q[i]);
      ioctl_download = 1'b0;
      for (int i = 0; i < 1000 && (busy || acc_q.size() < 5); i++) tick();
      n_cmp++; if (acc_q.size() !== 5) begin n_err++; $display("FAIL up_count: got %0d want 5", acc_q.size()); end
      for (int i = 0; i < 5; i++) begin
         got = (i < acc_q.size()) ? acc_q[i] : 8'hxx;
         n_cmp++; if (got !== exp_q[i]) begin n_err++; $display("FAIL up_byte%0d: got %h want %h", i, got, exp_q[i]); end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_line_endings();
      test_back_to_back();
      test_restart();
      test_disable();
      test_reset_in_gap();
      test_upcase();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
